fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//   Decoupling FIFO between the PC-generation/fetch stage and decode. Captures
//   each fetched {pc, instr} pair when fetch presents it valid, buffers up to
//   DEPTH entries, and presents them in order to decode over a valid/ready
//   handshake. Back-pressure (in_ready) drives the fetch stage's ready input.
//   Flushed on an EX-stage misprediction.
// PARAMETERS
//   DEPTH    4   number of entries; power of two, >= 2
//   PC_W     48  program-counter width
//   INSTR_W  32  instruction width
// PORTS
//   clk         in   1                clock, all state updates on rising edge
//   n_reset     in   1                asynchronous active-low reset
//   flush       in   1                mispredict from EX (mispred_ex); empties queue
//   in_valid    in   1                fetch stage has pc/instr this cycle
//   in_pc       in   PC_W             PC of fetched instruction
//   in_instr    in   INSTR_W          fetched instruction word
//   in_ready    out  1                queue can accept; feeds fetch stage ready
//   out_valid   out  1                head entry valid for decode
//   out_pc      out  PC_W             head entry PC
//   out_instr   out  INSTR_W          head entry instruction
//   out_ready   in   1                decode consumes head this cycle
//   count       out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//   - Reset (n_reset low, async): wr_ptr=rd_ptr=0, count=0, out_valid=0,
//     in_ready=1, out_pc=0, out_instr=0. Storage array is not reset.
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = (count != DEPTH); depends on registered count only, never on
//     out_ready (no push-while-full even if a pop occurs the same cycle).
//   - out_valid = (count != 0). out_pc/out_instr = mem[rd_ptr] when out_valid,
//     else 0.
//   - Latency: entry pushed at edge N is visible on out_* after edge N (i.e.
//     cycle N+1); no combinational in->out bypass.
//   - Push: mem[wr_ptr] <= {in_pc,in_instr}; wr_ptr <= wr_ptr+1 (mod DEPTH).
//   - Pop: rd_ptr <= rd_ptr+1 (mod DEPTH).
//   - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   - Pointers are $clog2(DEPTH) bits, wrap naturally; full/empty from count.
//   - Flush (sync, highest priority): on the edge where flush=1, wr_ptr=rd_ptr=0,
//     count=0; a push or pop in that cycle is discarded. in_ready=1 the next
//     cycle, so the corrected PC from fetch is accepted immediately.
//   - Full + pop: head leaves, count DEPTH-1, in_ready rises next cycle.
//   - Empty + push + out_ready: no pop (out_valid=0); entry appears next cycle.
//   - Reset asserted mid-operation discards all entries, same as power-on.
//   - in_pc/in_instr are ignored when push=0; X on them must not propagate.
// TESTING
//   1. Reset, then push pc=0x0,0x4,0x8 (instr 0xA0,0xA1,0xA2) with out_ready=0
//      -> count=3, in_ready=1, out_pc=0x0, out_instr=0xA0.
//   2. Push 4 with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored;
//      then out_ready=1 for 4 cycles -> pc 0x0,0x4,0x8,0xC in order, count=0.
//   3. Continuous push+pop for 3*DEPTH cycles (pc += 4) -> count steady at 1,
//      pointers wrap, every pc delivered exactly once in order.
//   4. Queue holds 3 entries; flush=1 with in_valid=1 pc=0x100 same cycle
//      -> next cycle count=0, out_valid=0; push pc=0x200 next -> out_pc=0x200.
//   5. Full queue, in_valid=1 and out_ready=1 same cycle -> pop only,
//      count=DEPTH-1, in_ready=1 after edge, blocked pc re-presented and taken.
//   6. Assert n_reset low asynchronously between edges with count=2
//      -> out_valid=0, count=0, in_ready=1 immediately, before next clk edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO: buffers {pc, instr} pairs and hands them to
// decode in order over valid/ready; flushed on an EX-stage misprediction.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 48,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = PC_W + INSTR_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;

  // Handshake flags come from registered occupancy only, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != CNT_W'(0));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign head      = mem_q[rd_ptr_q];
  assign out_pc    = out_valid ? head[ENT_W-1:INSTR_W] : '0;
  assign out_instr = out_valid ? head[INSTR_W-1:0]     : '0;

  // Next-state pointers and occupancy; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries inside the occupancy window are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

endmodule
